// File: rtl/irq_control_pkg.sv
// Shared definitions for the GM64 interrupt control stage: source numbering and
// the ICR bit positions used for the set/clear flag and the summary IR bit.
package gm64_irq_pkg;

    typedef enum logic [2:0] {
        SRC_TIMER_A = 3'd0,
        SRC_TIMER_B,
        SRC_TOD,
        SRC_SERIAL,
        SRC_FLAG
    } IrqSource;

    localparam int ICR_SET_CLEAR_BIT = 7;
    localparam int ICR_IR_BIT        = 7;

endpackage

// File: rtl/irq_control_if.sv
// CPU-side ICR register port: active-low select, read/write strobe and the
// 8-bit write/read data paths.
interface irq_control_if;

    logic       i_cs;
    logic       i_rw;
    logic [7:0] i_data;
    logic [7:0] o_data;

    modport master (
        output i_cs,
        output i_rw,
        output i_data,
        input  o_data
    );

    modport slave (
        input  i_cs,
        input  i_rw,
        input  i_data,
        output o_data
    );

endinterface

// File: rtl/irq_control_edge_rise.sv
// Registered rising-edge detector of configurable width: rise_o is high for the
// cycle in which level_i is high and was low at the previous clock edge.
module edge_rise #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] levelPrev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            levelPrev_q <= '0;
        end else begin
            levelPrev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~levelPrev_q;

endmodule

// File: rtl/irq_control.sv
// 6526-style interrupt control: latches source edges into flags, masks them and
// drives the active-low CPU IRQ. Define IRQ_CONTROL_6526_DELAY_EN for 2-clock assertion.
module irq_control
    import gm64_irq_pkg::*;
#(
    parameter int NUM_SRC = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    irq_control_if.slave       bus,
    input  logic [NUM_SRC-1:0] i_src,
    output logic               o_irq_n
);

    logic [NUM_SRC-1:0] srcRise;
    logic [NUM_SRC-1:0] flags_q;
    logic [NUM_SRC-1:0] flags_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mask_d;
    logic               csPrev_q;
    logic               irqN_q;
    logic               irqPending_d;
    logic               accessStart;
    logic               readClear;
    logic               maskWrite;
    logic [7:0]         rdData;
    logic               unusedData;

    edge_rise #(
        .WIDTH (NUM_SRC)
    ) u_srcEdge (
        .clk_i   (i_clk),
        .rst_ni  (i_reset),
        .level_i (i_src),
        .rise_o  (srcRise)
    );

    // A select held low over several clocks counts as a single access.
    assign accessStart = ~bus.i_cs & csPrev_q;
    assign readClear   = accessStart & bus.i_rw;
    assign maskWrite   = accessStart & ~bus.i_rw;
    assign unusedData  = ^bus.i_data;

    // A new edge beats a same-cycle read-clear, and a same-cycle mask write
    // already applies to it.
    always_comb begin
        flags_d = readClear ? '0 : flags_q;
        flags_d = flags_d | srcRise;
        mask_d  = mask_q;
        if (maskWrite) begin
            if (bus.i_data[ICR_SET_CLEAR_BIT]) begin
                mask_d = mask_q | bus.i_data[NUM_SRC-1:0];
            end else begin
                mask_d = mask_q & ~bus.i_data[NUM_SRC-1:0];
            end
        end
        irqPending_d = |(flags_d & mask_d);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            flags_q  <= '0;
            mask_q   <= '0;
            csPrev_q <= 1'b1;
        end else begin
            flags_q  <= flags_d;
            mask_q   <= mask_d;
            csPrev_q <= bus.i_cs;
        end
    end

`ifdef IRQ_CONTROL_6526_DELAY_EN
    logic pendDly_q;

    // Assertion needs the pending condition on two consecutive edges;
    // deassertion follows the pending condition directly.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pendDly_q <= 1'b0;
            irqN_q    <= 1'b1;
        end else begin
            pendDly_q <= irqPending_d;
            irqN_q    <= ~(irqPending_d & pendDly_q);
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            irqN_q <= 1'b1;
        end else begin
            irqN_q <= ~irqPending_d;
        end
    end
`endif

    assign o_irq_n = irqN_q;

    always_comb begin
        rdData = '0;
        if (~bus.i_cs & bus.i_rw) begin
            rdData[NUM_SRC-1:0] = flags_q;
            rdData[ICR_IR_BIT]  = |(flags_q & mask_q);
        end
    end

    assign bus.o_data = rdData;

endmodule

// File: tb/tb_irq_control.sv
// Directed self-checking bench for irq_control; expected IRQ latency follows
// IRQ_CONTROL_6526_DELAY_EN when the bench is built with that macro.
module tb_irq_control;
    import gm64_irq_pkg::*;

`ifdef IRQ_CONTROL_6526_DELAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       resetN;
    logic [4:0] src;
    logic       irqN;
    int         checks;
    int         passes;

    irq_control_if bus ();

    irq_control #(
        .NUM_SRC (5)
    ) dut (
        .i_clk   (clk),
        .i_reset (resetN),
        .bus     (bus),
        .i_src   (src),
        .o_irq_n (irqN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input logic [7:0] d);
        bus.i_cs   = 1'b0;
        bus.i_rw   = 1'b0;
        bus.i_data = d;
        tick();
        bus.i_cs   = 1'b1;
        tick();
    endtask

    task automatic cpuRead(output logic [7:0] d, output logic irqAfter);
        bus.i_cs = 1'b0;
        bus.i_rw = 1'b1;
        #1;
        d = bus.o_data;
        tick();
        irqAfter = irqN;
        bus.i_cs = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic       ia;
        resetN = 1'b0;
        tick();
        tick();
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL reset_irq: got %b want 1", irqN);
        else passes++;
        resetN = 1'b1;
        tick();
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h00) $display("[TB] FAIL reset_read: got %h want 00", d);
        else passes++;
    endtask

    task automatic test_mask_timer_a;
        logic [7:0] d;
        logic       ia;
        cpuWrite(8'h81);
        src[SRC_TIMER_A] = 1'b1;
        tick();
        src[SRC_TIMER_A] = 1'b0;
        checks++;
        if (irqN !== (LAT == 1 ? 1'b0 : 1'b1)) $display("[TB] FAIL ta_first_edge: got %b want %b", irqN, (LAT == 1 ? 1'b0 : 1'b1));
        else passes++;
        tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL ta_asserted: got %b want 0", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h81) $display("[TB] FAIL ta_read: got %h want 81", d);
        else passes++;
        checks++;
        if (ia !== 1'b1) $display("[TB] FAIL ta_clear_irq: got %b want 1", ia);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h00) $display("[TB] FAIL ta_second_read: got %h want 00", d);
        else passes++;
    endtask

    task automatic test_mask_program;
        logic [7:0] d;
        logic       ia;
        cpuWrite(8'h01);
        src[SRC_TIMER_B] = 1'b1;
        tick();
        src[SRC_TIMER_B] = 1'b0;
        tick();
        tick();
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL tb_unmasked_irq: got %b want 1", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h02) $display("[TB] FAIL tb_unmasked_read: got %h want 02", d);
        else passes++;
        src[SRC_TIMER_B] = 1'b1;
        tick();
        src[SRC_TIMER_B] = 1'b0;
        tick();
        cpuWrite(8'h82);
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL tb_mask_set_irq: got %b want 0", irqN);
        else passes++;
        cpuWrite(8'h02);
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL tb_mask_clear_irq: got %b want 1", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h02) $display("[TB] FAIL tb_flag_kept: got %h want 02", d);
        else passes++;
    endtask

    task automatic test_level_held;
        logic [7:0] d;
        logic       ia;
        cpuWrite(8'h81);
        src[SRC_TIMER_A] = 1'b1;
        repeat (10) tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL lvl_irq: got %b want 0", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h81) $display("[TB] FAIL lvl_read: got %h want 81", d);
        else passes++;
        tick();
        tick();
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL lvl_no_reset_irq: got %b want 1", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h00) $display("[TB] FAIL lvl_no_reset_read: got %h want 00", d);
        else passes++;
        src[SRC_TIMER_A] = 1'b0;
        tick();
        src[SRC_TIMER_A] = 1'b1;
        tick();
        tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL lvl_rearm_irq: got %b want 0", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h81) $display("[TB] FAIL lvl_rearm_read: got %h want 81", d);
        else passes++;
        src[SRC_TIMER_A] = 1'b0;
        tick();
    endtask

    task automatic test_read_collision;
        logic [7:0] d;
        logic       ia;
        bus.i_cs = 1'b0;
        bus.i_rw = 1'b1;
        src[SRC_TIMER_A] = 1'b1;
        #1;
        checks++;
        if (bus.o_data !== 8'h00) $display("[TB] FAIL coll_read_data: got %h want 00", bus.o_data);
        else passes++;
        tick();
        src[SRC_TIMER_A] = 1'b0;
        bus.i_cs = 1'b1;
        checks++;
        if (irqN !== (LAT == 1 ? 1'b0 : 1'b1)) $display("[TB] FAIL coll_edge_irq: got %b want %b", irqN, (LAT == 1 ? 1'b0 : 1'b1));
        else passes++;
        tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL coll_irq: got %b want 0", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h81) $display("[TB] FAIL coll_flag_survived: got %h want 81", d);
        else passes++;
    endtask

    task automatic test_write_collision;
        logic [7:0] d;
        logic       ia;
        bus.i_cs   = 1'b0;
        bus.i_rw   = 1'b0;
        bus.i_data = 8'h84;
        src[SRC_TOD] = 1'b1;
        tick();
        src[SRC_TOD] = 1'b0;
        bus.i_cs = 1'b1;
        checks++;
        if (irqN !== (LAT == 1 ? 1'b0 : 1'b1)) $display("[TB] FAIL wcoll_edge_irq: got %b want %b", irqN, (LAT == 1 ? 1'b0 : 1'b1));
        else passes++;
        tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL wcoll_irq: got %b want 0", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h84) $display("[TB] FAIL wcoll_read: got %h want 84", d);
        else passes++;
    endtask

    // Emulates a continuous-mode counter with start value 3: one pulse every 3 clocks.
    task automatic test_counter_stream;
        for (int p = 0; p < 3; p++) begin
            src[SRC_TIMER_A] = 1'b1;
            tick();
            src[SRC_TIMER_A] = 1'b0;
            checks++;
            if (irqN !== (LAT == 1 ? 1'b0 : 1'b1)) $display("[TB] FAIL cnt%0d_edge_irq: got %b want %b", p, irqN, (LAT == 1 ? 1'b0 : 1'b1));
            else passes++;
            tick();
            checks++;
            if (irqN !== 1'b0) $display("[TB] FAIL cnt%0d_irq: got %b want 0", p, irqN);
            else passes++;
            bus.i_cs = 1'b0;
            bus.i_rw = 1'b1;
            #1;
            checks++;
            if (bus.o_data !== 8'h81) $display("[TB] FAIL cnt%0d_read: got %h want 81", p, bus.o_data);
            else passes++;
            tick();
            bus.i_cs = 1'b1;
            checks++;
            if (irqN !== 1'b1) $display("[TB] FAIL cnt%0d_clear: got %b want 1", p, irqN);
            else passes++;
        end
        tick();
    endtask

`ifdef IRQ_CONTROL_6526_DELAY_EN
    task automatic test_delay_cancel;
        src[SRC_TIMER_A] = 1'b1;
        tick();
        src[SRC_TIMER_A] = 1'b0;
        bus.i_cs = 1'b0;
        bus.i_rw = 1'b1;
        tick();
        bus.i_cs = 1'b1;
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL dly_cancel: got %b want 1", irqN);
        else passes++;
        tick();
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL dly_cancel_hold: got %b want 1", irqN);
        else passes++;
    endtask
`endif

    task automatic test_reset_mid_access;
        logic [7:0] d;
        logic       ia;
        src[SRC_TIMER_A] = 1'b1;
        tick();
        src[SRC_TIMER_A] = 1'b0;
        tick();
        checks++;
        if (irqN !== 1'b0) $display("[TB] FAIL rst_pre_irq: got %b want 0", irqN);
        else passes++;
        bus.i_cs = 1'b0;
        bus.i_rw = 1'b1;
        resetN   = 1'b0;
        #1;
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL rst_async_irq: got %b want 1", irqN);
        else passes++;
        checks++;
        if (bus.o_data !== 8'h00) $display("[TB] FAIL rst_async_data: got %h want 00", bus.o_data);
        else passes++;
        bus.i_cs = 1'b1;
        tick();
        resetN = 1'b1;
        tick();
        src[SRC_TIMER_A] = 1'b1;
        tick();
        src[SRC_TIMER_A] = 1'b0;
        tick();
        checks++;
        if (irqN !== 1'b1) $display("[TB] FAIL rst_mask_cleared: got %b want 1", irqN);
        else passes++;
        cpuRead(d, ia);
        checks++;
        if (d !== 8'h01) $display("[TB] FAIL rst_read: got %h want 01", d);
        else passes++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        resetN     = 1'b0;
        src        = '0;
        bus.i_cs   = 1'b1;
        bus.i_rw   = 1'b1;
        bus.i_data = 8'h00;
        test_reset();
        test_mask_timer_a();
        test_mask_program();
        test_level_held();
        test_read_collision();
        test_write_collision();
        test_counter_stream();
`ifdef IRQ_CONTROL_6526_DELAY_EN
        test_delay_cancel();
`endif
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irq_control.md
Name: irq_control

Overview:
- Interrupt control stage directly downstream of the counter block. It consumes the counter's o_irq pulse plus other peripheral interrupt sources.
- Latches each source into a flag register and gates the flags with a CPU-programmable mask. Drives the active-low IRQ line to the 6510 core.
- Provides a 6526-style ICR: a read returns the flags and clears them; a write sets or clears mask bits.

Parameters:
- NUM_SRC, 5, number of interrupt sources (bit0 timer A, bit1 timer B, bit2 TOD alarm, bit3 serial, bit4 FLAG); legal range 1..7.

Ports:
- i_clk  input  1  system clock, single clock domain
- i_reset  input  1  asynchronous reset, active low
- i_cs  input  1  ICR register select, active low
- i_rw  input  1  1 = read, 0 = write; sampled while i_cs low
- i_data  input  8  write data
- o_data  output  8  read data
- i_src  input  NUM_SRC  interrupt source levels, active high (e.g. counter o_irq)
- o_irq_n  output  1  interrupt request to CPU, active low

Behaviour:
- Reset (i_reset low, asynchronous): flags=0, mask=0, src_prev=0, cs_prev=1, o_irq_n=1, o_data=0.
- Source capture:
  - Each i_src bit is rising-edge detected against src_prev, which is registered every clock.
  - A rising edge sets flags[k] at the same clock edge.
  - A level held high for N cycles sets the flag once. Held high through a clear, it does not re-set the flag until it falls and rises again.
- Access start: an access begins on the first clock where i_cs is low and cs_prev is 1. A CS held low for several cycles is one access.
- Read (access start, i_rw=1):
  - o_data is combinational while i_cs low and i_rw=1: bits[NUM_SRC-1:0]=flags, bit7=|(flags & mask), other bits 0. It is 0 otherwise.
  - At the clock edge ending the access-start cycle, flags clear and o_irq_n returns to 1 on that edge.
- Write (access start, i_rw=0):
  - i_data[7]=1: mask |= i_data[NUM_SRC-1:0].
  - i_data[7]=0: mask &= ~i_data[NUM_SRC-1:0].
  - Bits above NUM_SRC are ignored.
- IRQ output:
  - o_irq_n is registered: next = ~|(flags_next & mask_next). Latency from source edge to o_irq_n low is 1 clock.
  - Setting a mask bit for an already-pending flag asserts o_irq_n on the next edge.
  - Clearing the mask bit of the only pending source deasserts it on the next edge. The flag itself stays set.
- Simultaneous events:
  - Source edge in the same cycle as a read-clear: set wins. The new flag survives, and o_irq_n stays/goes low if masked. The value returned by that read does not include the new edge.
  - Source edge in the same cycle as a mask write: the new mask applies to the new flag.
- Reset mid-access clears everything immediately. The access is not completed after reset release unless CS returns high then low.

Optional Feature:
- Macro IRQ_CONTROL_6526_DELAY_EN.
- Defined: one extra register stage on o_irq_n assertion only, so source edge to o_irq_n low takes 2 clocks (original 6526 behaviour). Deassertion remains 1 clock.
  - A read-clear in the delay cycle cancels the pending assertion unless a same-cycle set occurs.
- Undefined: 1-clock assertion as above (8521 behaviour).

Decomposition:
- Shared package gm64_irq_pkg:
  - typedef IrqSource enum: SRC_TIMER_A=0, SRC_TIMER_B, SRC_TOD, SRC_SERIAL, SRC_FLAG.
  - localparam ICR_SET_CLEAR_BIT=7.
  - localparam ICR_IR_BIT=7.
- One sub-module edge_rise: a parameterised width-N registered rising-edge detector with async active-low reset, instantiated on i_src.

Test Plan:
- Reset low 2 cycles -> o_irq_n=1; read ICR returns 0x00.
- Write 0x81 (mask timer A), pulse i_src[0] 1 cycle -> o_irq_n=0 one clock later. Read -> o_data=0x81; after read edge o_irq_n=1; second read -> 0x00.
- Mask=0, pulse i_src[1] -> o_irq_n stays 1, read -> 0x02. Re-pulse, write 0x82 -> o_irq_n=0 next clock. Write 0x02 -> o_irq_n=1 next clock, read -> 0x02.
- i_src[0] held high 10 cycles with mask 0x01 -> one flag set; read clears it; no re-set while still high. Drop and raise -> set again.
- Read-clear cycle coincident with i_src[0] rising edge, mask 0x01 -> read data 0x00, flags=0x01 after edge, o_irq_n=0.
- Counter instance in CONTINUOUS mode, start value 3, feeding i_src[0] -> flag sets every 3 clocks. With IRQ_CONTROL_6526_DELAY_EN, o_irq_n falls 2 clocks after each counter o_irq rise instead of 1.
